// File: rtl/usb_uart_in_arbiter.sv
// Round-robin, message-locked arbiter feeding the usb_uart_core IN byte pipeline.
// Optional source-tag byte before each message: define USB_UART_ARB_TAG_EN.
module usb_uart_in_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
`ifdef USB_UART_ARB_TAG_EN
  ,
  parameter logic [7:0] TAG_BASE = 8'hF0
`endif
) (
  input  logic                 clk_48mhz,
  input  logic                 reset_n,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_in_data,
  output logic                 uart_in_valid,
  input  logic                 uart_in_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

`ifdef USB_UART_ARB_TAG_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PASS = 2'd1, S_TAG = 2'd2} state_e;
`else
  typedef enum logic {S_IDLE = 1'b0, S_PASS = 1'b1} state_e;
`endif

  state_e          state_q;
  logic [ID_W-1:0] grant_id_q;
  logic [ID_W-1:0] ptr_q;

  logic            any_req_d;
  logic [ID_W-1:0] sel_id_d;
  logic            found_hi, found_lo;
  logic [ID_W-1:0] hi_id, lo_id;

  logic            g_valid, g_last;
  logic [7:0]      g_data;

  // Rotating priority: indices above the pointer first, then wrap to 0..ptr.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_hi && req_valid[i] && (i > int'(ptr_q))) begin
        found_hi = 1'b1;
        hi_id    = ID_W'(i);
      end
      if (!found_lo && req_valid[i] && (i <= int'(ptr_q))) begin
        found_lo = 1'b1;
        lo_id    = ID_W'(i);
      end
    end
    any_req_d = found_hi | found_lo;
    sel_id_d  = found_hi ? hi_id : lo_id;
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id_q) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      grant_id_q <= '0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            grant_id_q <= sel_id_d;
            ptr_q      <= sel_id_d;
`ifdef USB_UART_ARB_TAG_EN
            state_q    <= S_TAG;
`else
            state_q    <= S_PASS;
`endif
          end
        end
`ifdef USB_UART_ARB_TAG_EN
        S_TAG: begin
          if (uart_in_ready) state_q <= S_PASS;
        end
`endif
        S_PASS: begin
          // Lock until the granted requester's last byte is actually transferred.
          if (g_valid && g_last && uart_in_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    uart_in_valid = 1'b0;
    uart_in_data  = 8'h00;
    req_ready     = '0;
    case (state_q)
      S_PASS: begin
        uart_in_valid = g_valid;
        uart_in_data  = g_data;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (ID_W'(i) == grant_id_q) req_ready[i] = uart_in_ready;
        end
      end
`ifdef USB_UART_ARB_TAG_EN
      S_TAG: begin
        uart_in_valid = 1'b1;
        uart_in_data  = TAG_BASE | 8'(grant_id_q);
      end
`endif
      default: ;
    endcase
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_uart_in_arbiter.sv
// Self-checking bench for usb_uart_in_arbiter: arbitration vector table plus
// scoreboarded multi-cycle sequences (lock, backpressure, reset, throughput).
module tb_usb_uart_in_arbiter;
  localparam int N = 4;

  logic           clk_48mhz;
  logic           reset_n;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_in_data;
  logic           uart_in_valid;
  logic           uart_in_ready;
  logic [1:0]     grant_id;
  logic           busy;

  usb_uart_in_arbiter dut (
    .clk_48mhz    (clk_48mhz),
    .reset_n      (reset_n),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_in_data (uart_in_data),
    .uart_in_valid(uart_in_valid),
    .uart_in_ready(uart_in_ready),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  int checks = 0;
  int failures = 0;

  logic [8:0] src_q [N][$];   // {last, data} per requester
  logic [7:0] exp_q [$];      // host byte scoreboard
  logic [N-1:0] stall = '0;
  logic [N-1:0] acc = '0;
  int ready_mode = 0;          // 0: ready=1, 1: random, 2: ready=0
  int cyc = 0;
  bit record = 0;
  int acc_times [$];
  bit stalled_prev = 0;
  logic [7:0] data_prev = 8'h00;

  initial begin
    clk_48mhz = 1'b0;
    forever #5 clk_48mhz = ~clk_48mhz;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Requester models: present queue head, retire it when accepted.
  initial begin
    req_valid = '0; req_last = '0; req_data = '0; uart_in_ready = 1'b1;
    forever begin
      @(posedge clk_48mhz);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        req_valid[i] = (src_q[i].size() > 0) && !stall[i];
        if (stall[i]) begin
          req_last[i] = 1'b1;
          req_data[8*i +: 8] = 8'hEE;
        end else if (src_q[i].size() > 0) begin
          req_last[i] = src_q[i][0][8];
          req_data[8*i +: 8] = src_q[i][0][7:0];
        end else begin
          req_last[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
        end
      end
      case (ready_mode)
        0: uart_in_ready = 1'b1;
        1: uart_in_ready = 1'($urandom_range(0, 1));
        default: uart_in_ready = 1'b0;
      endcase
    end
  end

  // Host side: scoreboard compare on every transfer, hold check while stalled.
  initial begin
    forever begin
      @(negedge clk_48mhz);
      cyc++;
      for (int i = 0; i < N; i++) acc[i] = req_valid[i] & req_ready[i];
      if (!reset_n) begin
        stalled_prev = 0;
      end else begin
        if (stalled_prev) begin
          chk("hold_valid", 32'(uart_in_valid), 32'd1);
          chk("hold_data", 32'(uart_in_data), 32'(data_prev));
        end
        if (uart_in_valid && uart_in_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL host_unexpected actual=%0h required=none", uart_in_data);
          end else begin
            chk("host_byte", 32'(uart_in_data), 32'(exp_q.pop_front()));
          end
        end
        if (record && acc[3]) acc_times.push_back(cyc);
        stalled_prev = uart_in_valid && !uart_in_ready;
        data_prev = uart_in_data;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_tag(input int r);
`ifdef USB_UART_ARB_TAG_EN
    exp_q.push_back(8'hF0 | 8'(r));
`endif
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    src_q[r].push_back({last, d});
    exp_q.push_back(d);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    stall = '0;
    acc = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_all();
    ready_mode = 0;
    repeat (2) @(negedge clk_48mhz);
    reset_n = 1'b1;
    @(negedge clk_48mhz);
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk_48mhz);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain actual=%0d_left required=0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk_48mhz);
  endtask

  typedef struct {
    int         prev;   // requester served just before (-1: straight from reset)
    logic [3:0] mask;   // requesters raising valid together
    logic [1:0] gid;    // requester that must win
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [7:0] exp_d;
    int         n;
    vecs[0] = '{-1, 4'b1111, 2'd0};
    vecs[1] = '{-1, 4'b0100, 2'd2};
    vecs[2] = '{ 0, 4'b0011, 2'd1};
    vecs[3] = '{ 1, 4'b0011, 2'd0};
    vecs[4] = '{ 3, 4'b1000, 2'd3};
    vecs[5] = '{ 2, 4'b1010, 2'd3};
    vecs[6] = '{ 3, 4'b1001, 2'd0};
    vecs[7] = '{ 2, 4'b0101, 2'd0};

    reset_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_valid", 32'(uart_in_valid), 32'd0);
    chk("rst_data", 32'(uart_in_data), 32'd0);
    do_reset();

    // Arbitration table: winner observed with the host stalled.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      if (vecs[v].prev >= 0) begin
        push_tag(vecs[v].prev);
        push_byte(vecs[v].prev, 8'hA0 + 8'(vecs[v].prev), 1'b1);
        wait_drain(20, "vec_prev");
      end
      ready_mode = 2;
      for (int i = 0; i < N; i++)
        if (vecs[v].mask[i]) src_q[i].push_back({1'b1, 8'hA0 + 8'(i)});
      repeat (3) @(negedge clk_48mhz);
`ifdef USB_UART_ARB_TAG_EN
      exp_d = 8'hF0 | {6'd0, vecs[v].gid};
`else
      exp_d = 8'hA0 + {6'd0, vecs[v].gid};
`endif
      chk($sformatf("vec%0d_grant", v), 32'(grant_id), 32'(vecs[v].gid));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'd1);
      chk($sformatf("vec%0d_valid", v), 32'(uart_in_valid), 32'd1);
      chk($sformatf("vec%0d_data", v), 32'(uart_in_data), 32'(exp_d));
      chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'd0);
    end

    // Reset in the middle of a granted message.
    do_reset();
    ready_mode = 2;
    src_q[1].push_back({1'b0, 8'h11});
    src_q[1].push_back({1'b1, 8'h22});
    repeat (4) @(negedge clk_48mhz);
    chk("t1_busy_pre", 32'(busy), 32'd1);
    chk("t1_grant_pre", 32'(grant_id), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_ready", 32'(req_ready), 32'd0);
    chk("t1_valid", 32'(uart_in_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_grant", 32'(grant_id), 32'd0);
    clear_all();
    ready_mode = 0;
    repeat (2) @(negedge clk_48mhz);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_48mhz);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Single 3-byte message, one-cycle grant latency.
    do_reset();
    push_tag(1);
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h22, 1'b0);
    push_byte(1, 8'h33, 1'b1);
    @(negedge clk_48mhz);
    chk("t2_busy_req_cycle", 32'(busy), 32'd0);
    @(negedge clk_48mhz);
    chk("t2_busy_next", 32'(busy), 32'd1);
    chk("t2_grant", 32'(grant_id), 32'd1);
    wait_drain(20, "t2");

    // All four at once from reset: served 0,1,2,3 without interleave.
    do_reset();
    for (int i = 0; i < N; i++) begin
      push_tag(i);
      push_byte(i, {4'(i), 4'hA}, 1'b0);
      push_byte(i, {4'(i), 4'hB}, 1'b1);
    end
    wait_drain(60, "t3");
    chk("t3_grant_last", 32'(grant_id), 32'd3);

    // Lock: granted requester pauses mid-message, another waits.
    do_reset();
    push_tag(2);
    push_byte(2, 8'hC1, 1'b0);
    push_byte(2, 8'hC2, 1'b0);
    push_byte(2, 8'hC3, 1'b1);
    n = 0;
    while (!(req_valid[2] && req_ready[2]) && n < 10) begin
      @(negedge clk_48mhz);
      n++;
    end
    chk("t4_first_accept", 32'(req_valid[2] && req_ready[2]), 32'd1);
    stall[2] = 1'b1;
    push_tag(0);
    push_byte(0, 8'h01, 1'b0);
    push_byte(0, 8'h02, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_48mhz);
      chk("t4_req0_ready", 32'(req_ready[0]), 32'd0);
      chk("t4_grant", 32'(grant_id), 32'd2);
    end
    stall[2] = 1'b0;
    wait_drain(40, "t4");
    chk("t4_grant_end", 32'(grant_id), 32'd0);

    // Random backpressure over a 16-byte message.
    do_reset();
    ready_mode = 1;
    push_tag(1);
    for (int k = 0; k < 16; k++) push_byte(1, 8'h40 + 8'(k), 1'(k == 15));
    wait_drain(400, "t5");
    ready_mode = 0;

    // Sole requester with back-to-back single-byte messages.
    do_reset();
    acc_times.delete();
    record = 1;
    for (int k = 0; k < 6; k++) begin
      push_tag(3);
      push_byte(3, 8'h60 + 8'(k), 1'b1);
    end
    wait_drain(60, "t6");
    record = 0;
    chk("t6_count", 32'(acc_times.size()), 32'd6);
    for (int k = 1; k < acc_times.size(); k++) begin
`ifdef USB_UART_ARB_TAG_EN
      chk("t6_spacing", 32'(acc_times[k] - acc_times[k-1]), 32'd3);
`else
      chk("t6_spacing", 32'(acc_times[k] - acc_times[k-1]), 32'd2);
`endif
    end

    repeat (3) @(negedge clk_48mhz);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
